sequential_counter_param: RTL
=============================

Name: sequential_counter_param

Overview:
- Parametrised successor to the team's 16-bit enabled counter user design for FABulous fabric bring-up.
- Adds configurable width, up/down direction, synchronous load, modulo and one-shot modes, a clock prescaler, a terminal-count pulse and a compare-match flag.
- Counter is generic fabric logic (LUT + FF chains). It is used as a fabric test design and as a timer source for other user designs.

Parameters:
- WIDTH, 16: counter, load, modulus and compare width (>=2).
- PRESCALE_W, 4: prescaler divide-select width (>=1).

Ports:
- clk  in  1  fabric global clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; highest priority.
- enable  in  1  count enable; gates the prescaler and the count.
- up_down  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value written on load.
- mode  in  2  00 free-run, 01 modulo, 10 one-shot, 11 reserved (behaves as 00).
- modulus  in  WIDTH  terminal value for modes 01 and 10.
- prescale  in  PRESCALE_W  advance once every prescale+1 enabled cycles.
- compare  in  WIDTH  match reference.
- counter  out  WIDTH  registered count value.
- tc  out  1  registered one-cycle terminal-count pulse.
- running  out  1  registered; 0 only when a one-shot has completed.
- match  out  1  combinational: counter == compare.

Behaviour:
- Power-up (initial) and reset state: counter=0, prescale_cnt=0, tc=0, running=1.
- Priority per cycle: reset > load > tick > hold.
- Reset is not gated by enable.
- Load: counter<=load_value, prescale_cnt<=0, running<=1, tc<=0. Load is accepted regardless of enable.
- Prescaler:
  - tick = enable & running & (prescale_cnt==prescale).
  - On tick, prescale_cnt<=0.
  - Else, if enable & running, prescale_cnt increments.
  - Else, prescale_cnt holds.
  - prescale=0 gives a tick on every enabled cycle.
  - A change to prescale takes effect against the current prescale_cnt. If prescale_cnt>prescale, it counts up through 2^PRESCALE_W-1, wraps to 0, then proceeds normally.
- On tick, by mode:
  - 00 up: counter+1, mod 2^WIDTH. At all-ones → 0 with tc=1.
  - 00 down: counter-1. At 0 → all-ones with tc=1.
  - 01 up: if counter>=modulus → 0 with tc=1; else +1.
  - 01 down: if counter==0 → modulus with tc=1; if counter>modulus → modulus with tc=0; else -1.
  - 10 up: if counter>=modulus → counter holds, running<=0, tc=1; else +1.
  - 10 down: if counter==0 → counter holds, running<=0, tc=1; else -1.
- tc: high exactly one cycle, the cycle in which counter shows the post-event value. It is 0 on every cycle without a terminal event.
- modulus=0 in mode 01: counter stays 0 and tc pulses on every tick.
- Timing of mode, modulus and up_down: sampled on the tick cycle. A change takes effect on the next tick, with no glitch on counter.
- Once running=0, only load or reset resumes counting. enable has no effect while stopped.
- Reset mid-prescale or mid-one-shot: all state returns to reset values the next cycle. No pending tc survives.
- Arithmetic is unsigned WIDTH-bit. No carry-out port.

Test Plan:
- Reset low, enable=1, mode=00, up, prescale=0, WIDTH=16, 70000 cycles → counter 0,1,2,…; wraps 65535→0 with a single tc pulse in that cycle.
- mode=01, modulus=9, up, prescale=2 → counter advances every 3rd enabled cycle 0..9,0. tc high only on the 9→0 cycle. Repeat with down: 0→9 with tc.
- mode=10, modulus=5, up, from reset → counts 0..5; next tick tc=1, running=0, counter holds 5 for 20 cycles. Then load=1, load_value=2 → running=1, resumes 3,4,5.
- load and tick in the same cycle, load_value=100 → counter=100 next cycle, no tc. Reset asserted together with load → counter=0.
- enable toggled 1-0-1 with prescale=3 → prescale_cnt freezes while enable=0. Total ticks = enabled cycles/4. compare=7 → match high exactly while counter==7.
- mode=01, down, counter loaded to 50, modulus=10 → next tick counter=10, tc=0. Then 9..0, and 0→10 with tc=1.

Source files
------------

// File: rtl/sequential_counter_param.sv
// Parametrised fabric counter/timer: up/down, synchronous load, free-run/modulo/one-shot modes,
// clock prescaler, registered terminal-count pulse and a combinational compare-match flag.
module sequential_counter_param #(
   parameter int WIDTH      = 16,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_down,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic [1:0]            mode,
   input  logic [WIDTH-1:0]      modulus,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [WIDTH-1:0]      compare,
   output logic [WIDTH-1:0]      counter,
   output logic                  tc,
   output logic                  running,
   output logic                  match
);

   localparam logic [1:0] MODE_MODULO  = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   // Declaration initialisers give the documented power-up state before the first reset.
   logic [WIDTH-1:0]      counter_q      = '0;
   logic [PRESCALE_W-1:0] prescale_cnt_q = '0;
   logic                  tc_q           = 1'b0;
   logic                  running_q      = 1'b1;

   logic [WIDTH-1:0]      counter_d;
   logic [PRESCALE_W-1:0] prescale_cnt_d;
   logic                  tc_d;
   logic                  running_d;
   logic                  active;
   logic                  tick;

   assign active = enable & running_q;
   assign tick   = active & (prescale_cnt_q == prescale);

   always_comb begin
      counter_d      = counter_q;
      prescale_cnt_d = prescale_cnt_q;
      running_d      = running_q;
      tc_d           = 1'b0;
      if (load) begin
         counter_d      = load_value;
         prescale_cnt_d = '0;
         running_d      = 1'b1;
      end else if (tick) begin
         prescale_cnt_d = '0;
         case (mode)
            MODE_MODULO: begin
               if (up_down) begin
                  if (counter_q >= modulus) begin
                     counter_d = '0;
                     tc_d      = 1'b1;
                  end else begin
                     counter_d = counter_q + 1'b1;
                  end
               end else if (counter_q == '0) begin
                  counter_d = modulus;
                  tc_d      = 1'b1;
               end else if (counter_q > modulus) begin
                  // Out-of-range count snaps back into range without a terminal event.
                  counter_d = modulus;
               end else begin
                  counter_d = counter_q - 1'b1;
               end
            end
            MODE_ONESHOT: begin
               if (up_down ? (counter_q >= modulus) : (counter_q == '0)) begin
                  running_d = 1'b0;
                  tc_d      = 1'b1;
               end else if (up_down) begin
                  counter_d = counter_q + 1'b1;
               end else begin
                  counter_d = counter_q - 1'b1;
               end
            end
            default: begin
               if (up_down) begin
                  counter_d = counter_q + 1'b1;
                  tc_d      = &counter_q;
               end else begin
                  counter_d = counter_q - 1'b1;
                  tc_d      = (counter_q == '0);
               end
            end
         endcase
      end else if (active) begin
         // Wraps through the full prescaler range if prescale was lowered below the count.
         prescale_cnt_d = prescale_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         counter_q      <= '0;
         prescale_cnt_q <= '0;
         tc_q           <= 1'b0;
         running_q      <= 1'b1;
      end else begin
         counter_q      <= counter_d;
         prescale_cnt_q <= prescale_cnt_d;
         tc_q           <= tc_d;
         running_q      <= running_d;
      end
   end

   assign counter = counter_q;
   assign tc      = tc_q;
   assign running = running_q;
   assign match   = (counter_q == compare);

endmodule
